unary_add_n_m: RTL and testbench
================================

UNARY_ADD_N_M -- requirements
Module: unary_add_n_m

Interface
REQ-001 SHALL have parameter LANES, default 2: number of unary input bits summed per accumulate cycle (1..MOD).
REQ-002 SHALL have parameter MOD, default 5: count modulus; reaching MOD emits a carry (MOD >= 2).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  cycle enable.
REQ-006 SHALL have port rw  input  1  mode: 0 = accumulate, 1 = emit.
REQ-007 SHALL have port din  input  LANES  unary input bits, each 1 adds one.
REQ-008 SHALL have port dout  output  1  registered serial unary output.
REQ-009 SHALL have port carry  output  1  registered one-cycle carry pulse.
REQ-010 SHALL have port done  output  1  registered pulse coincident with the last dout=1 of an emit.
REQ-011 SHALL have port busy  output  1  high while the internal count is non-zero.

Function
REQ-012 Internal count SHALL be CW = $clog2(MOD+LANES) bits wide and SHALL hold 0..MOD-1 between cycles.
REQ-013 en=0: count SHALL hold; dout, carry and done SHALL be 0 next cycle.
REQ-014 en=1, rw=0: sum = count + popcount(din); sum >= MOD -> count <= sum-MOD, carry <= 1; else count <= sum, carry <= 0.
REQ-015 A single wrap SHALL always suffice, because LANES <= MOD.
REQ-016 In accumulate, dout and done SHALL be 0 next cycle.
REQ-017 Carry SHALL assert on the same edge as the wrap, with no extra pipeline cycle.
REQ-018 en=1, rw=1, count != 0: dout <= 1; count <= count-1; done <= 1 only when count == 1.
REQ-019 en=1, rw=1, count == 0: dout <= 0 and done <= 0.
REQ-020 In emit, carry SHALL be 0 next cycle.
REQ-021 rw SHALL be switchable on any cycle: 1->0 mid-emit resumes accumulating from the remaining count; 0->1 starts emitting the current count.
REQ-022 busy SHALL equal (count != 0), combinationally from the count register.
REQ-023 A count of 0 SHALL emit no pulses and no done.

Reset
REQ-024 rst=1 SHALL asynchronously force count=0, dout=0, carry=0, done=0 and busy=0, overriding en and rw.
REQ-025 Reset mid-emit SHALL discard the remaining count; after release, no further pulses are emitted until new accumulation.

Configuration
REQ-026 Macro UNARY_ADD_THERM_OUT_EN defined: SHALL add output port therm  output  MOD-1  with therm[i] = (count > i), combinational from the count register.
REQ-027 Macro UNARY_ADD_THERM_OUT_EN undefined: port therm and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package unary_add_pkg SHALL hold the mode encodings (RW_ACC=0, RW_EMIT=1) and the CW width function.
REQ-029 Popcount SHALL be a sub-module, unary_popcount, parametrised by LANES with output width $clog2(LANES+1).

Verification (LANES=2, MOD=5)
REQ-030 Reset, rw=0; din=11, 11, 01 on three enabled cycles -> count 2, 4, then 0 with carry=1 for exactly one cycle.
REQ-031 Accumulate din=11 then 01 (count 3); then rw=1 for 4 cycles -> dout 1,1,1,0; done=1 only with the third 1; busy falls with it.
REQ-032 Count 4, din=11 -> count 1 and carry=1; then emit -> one dout pulse with done.
REQ-033 Count 3, emit one cycle, en=0 for 2 cycles (dout=0, count 2 held), en=1 -> dout 1,1, then 0.
REQ-034 Count 4, emitting; assert rst between edges -> all outputs 0 immediately; after release, rw=1 yields dout=0.
REQ-035 With UNARY_ADD_THERM_OUT_EN, count 3 -> therm=4'b0111; count 0 -> therm=4'b0000.

Source files
------------

// File: rtl/unary_add_pkg.sv
// unary_add_pkg: shared definitions for the unary modulo accumulator.
//   rw_mode_e : meaning of the rw input (accumulate / emit)
//   cw_width  : width of the internal count register
package unary_add_pkg;

  typedef enum logic {
    RW_ACC  = 1'b0,
    RW_EMIT = 1'b1
  } rw_mode_e;

  // Wide enough for count + popcount before the wrap: max MOD-1+LANES.
  function automatic int unsigned cw_width(input int unsigned mod, input int unsigned lanes);
    return $clog2(mod + lanes);
  endfunction

endpackage

// File: rtl/unary_popcount.sv
// unary_popcount: combinational count of set bits in a LANES-wide unary word.
//   din : input  [LANES-1:0]            unary input bits
//   cnt : output [$clog2(LANES+1)-1:0]  number of bits set in din
module unary_popcount #(
  parameter int unsigned LANES = 2
) (
  input  logic [LANES-1:0]               din,
  output logic [$clog2(LANES+1)-1:0]     cnt
);

  localparam int unsigned PW = $clog2(LANES + 1);

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      cnt = cnt + PW'(din[i]);
    end
  end

endmodule

// File: rtl/unary_add_n_m.sv
// unary_add_n_m: modulo-MOD accumulator of unary input bits with serial
// unary read-out.
//   clk   : input        rising-edge clock
//   rst   : input        asynchronous active-high reset
//   en    : input        cycle enable
//   rw    : input        0 = accumulate din, 1 = emit count as dout pulses
//   din   : input  [LANES-1:0] unary bits, each set bit adds one
//   dout  : output       registered serial unary output
//   carry : output       registered one-cycle pulse when the count wraps
//   done  : output       registered pulse with the last dout=1 of an emit
//   therm : output [MOD-2:0] thermometer view of the count
//           (present only when UNARY_ADD_THERM_OUT_EN is defined)
//   busy  : output       count is non-zero
module unary_add_n_m
  import unary_add_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned MOD   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rw,
  input  logic [LANES-1:0] din,
  output logic             dout,
  output logic             carry,
  output logic             done,
`ifdef UNARY_ADD_THERM_OUT_EN
  output logic [MOD-2:0]   therm,
`endif
  output logic             busy
);

  localparam int unsigned CW = cw_width(MOD, LANES);
  localparam int unsigned PW = $clog2(LANES + 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] sum;
  logic [PW-1:0] pop;
  logic          dout_nxt;
  logic          carry_nxt;
  logic          done_nxt;
  rw_mode_e      mode;

  unary_popcount #(
    .LANES(LANES)
  ) u_popcount (
    .din(din),
    .cnt(pop)
  );

  assign mode = rw_mode_e'(rw);
  assign sum  = count + CW'(pop);

  always_comb begin
    count_nxt = count;
    dout_nxt  = 1'b0;
    carry_nxt = 1'b0;
    done_nxt  = 1'b0;
    if (en) begin
      if (mode == RW_ACC) begin
        // LANES <= MOD, so one subtraction always brings sum below MOD.
        if (sum >= CW'(MOD)) begin
          count_nxt = sum - CW'(MOD);
          carry_nxt = 1'b1;
        end else begin
          count_nxt = sum;
        end
      end else if (count != '0) begin
        count_nxt = count - CW'(1);
        dout_nxt  = 1'b1;
        done_nxt  = (count == CW'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      dout  <= 1'b0;
      carry <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_nxt;
      dout  <= dout_nxt;
      carry <= carry_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (count != '0);

`ifdef UNARY_ADD_THERM_OUT_EN
  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < MOD - 1; i++) begin
      therm[i] = (count > CW'(i));
    end
  end
`endif

endmodule

// File: tb/tb_unary_add_n_m.sv
// tb_unary_add_n_m: self-checking bench for unary_add_n_m (LANES=2, MOD=5).
// Directed scenarios followed by random enable/mode/data steps, each checked
// against an arithmetic reference model of the count.
module tb_unary_add_n_m;
  import unary_add_pkg::*;

  localparam int unsigned LANES = 2;
  localparam int unsigned MOD   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             rw  = 1'b0;
  logic [LANES-1:0] din = '0;
  logic             dout;
  logic             carry;
  logic             done;
  logic             busy;
`ifdef UNARY_ADD_THERM_OUT_EN
  logic [MOD-2:0]   therm;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int   m_count = 0;
  logic e_dout  = 1'b0;
  logic e_carry = 1'b0;
  logic e_done  = 1'b0;

  unary_add_n_m #(
    .LANES(LANES),
    .MOD  (MOD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .rw   (rw),
    .din  (din),
    .dout (dout),
    .carry(carry),
    .done (done),
`ifdef UNARY_ADD_THERM_OUT_EN
    .therm(therm),
`endif
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"},  dout,  e_dout);
    chk({tag, ".carry"}, carry, e_carry);
    chk({tag, ".done"},  done,  e_done);
    chk({tag, ".busy"},  busy,  m_count != 0);
`ifdef UNARY_ADD_THERM_OUT_EN
    for (int i = 0; i < int'(MOD) - 1; i++) begin
      chk({tag, ".therm"}, therm[i], m_count > i);
    end
`endif
  endtask

  // One clock cycle with the given inputs; model and check after the edge.
  task automatic step(input string tag, input logic e, input logic r, input logic [LANES-1:0] d);
    int s;
    @(negedge clk);
    en = e; rw = r; din = d;
    @(posedge clk);
    e_dout = 1'b0; e_carry = 1'b0; e_done = 1'b0;
    if (e) begin
      if (r == RW_ACC) begin
        s = m_count + $countones(d);
        e_carry = (s >= int'(MOD));
        m_count = s % int'(MOD);
      end else if (m_count > 0) begin
        e_dout  = 1'b1;
        e_done  = (m_count == 1);
        m_count = m_count - 1;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; rw = 1'b0; din = '0;
    m_count = 0; e_dout = 1'b0; e_carry = 1'b0; e_done = 1'b0;
    @(posedge clk); #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Initial reset
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // Accumulate 2, 4, then wrap to 0 with carry
    step("acc_11a", 1'b1, 1'b0, 2'b11);
    step("acc_11b", 1'b1, 1'b0, 2'b11);
    step("acc_wrap", 1'b1, 1'b0, 2'b01);
    step("acc_idle", 1'b1, 1'b0, 2'b00);
    step("emit_zero", 1'b1, 1'b1, 2'b00);

    // Count 3, emit 1,1,1,0
    step("acc3a", 1'b1, 1'b0, 2'b11);
    step("acc3b", 1'b1, 1'b0, 2'b01);
    for (int i = 0; i < 4; i++) step("emit3", 1'b1, 1'b1, 2'b00);

    // Count 4 + 2 -> 1 with carry, then one pulse with done
    step("acc4a", 1'b1, 1'b0, 2'b11);
    step("acc4b", 1'b1, 1'b0, 2'b11);
    step("wrap1", 1'b1, 1'b0, 2'b11);
    step("emit1", 1'b1, 1'b1, 2'b00);
    step("emit1_end", 1'b1, 1'b1, 2'b00);

    // Count 3, emit one, hold two, then finish
    step("h_acc_a", 1'b1, 1'b0, 2'b11);
    step("h_acc_b", 1'b1, 1'b0, 2'b10);
    step("h_emit", 1'b1, 1'b1, 2'b00);
    step("h_hold", 1'b0, 1'b1, 2'b11);
    step("h_hold", 1'b0, 1'b0, 2'b11);
    for (int i = 0; i < 3; i++) step("h_resume", 1'b1, 1'b1, 2'b00);

    // Mid-emit switch back to accumulate
    step("sw_acc", 1'b1, 1'b0, 2'b11);
    step("sw_acc", 1'b1, 1'b0, 2'b01);
    step("sw_emit", 1'b1, 1'b1, 2'b00);
    step("sw_back", 1'b1, 1'b0, 2'b11);
    for (int i = 0; i < 5; i++) step("sw_drain", 1'b1, 1'b1, 2'b00);

    // Count 4, emitting, asynchronous reset between edges
    step("r_acc", 1'b1, 1'b0, 2'b11);
    step("r_acc", 1'b1, 1'b0, 2'b11);
    step("r_emit", 1'b1, 1'b1, 2'b00);
    @(negedge clk);
    #2;
    rst = 1'b1;
    m_count = 0; e_dout = 1'b0; e_carry = 1'b0; e_done = 1'b0;
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 1'b1, 1'b1, 2'b00);
    step("post_rst", 1'b1, 1'b1, 2'b00);

    // Random stimulus
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           LANES'($urandom_range(0, 3)));
    end

    do_reset();
    step("final", 1'b1, 1'b1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
